// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   MEM-stage initiator for a word-addressed synchronous data memory
//   (32-bit words, read data valid one cycle after the read strobe).
//   Takes byte-addressed load/store requests, handles byte/half/word sizes,
//   sign/zero-extends loads and performs read-modify-write for sub-word
//   stores, because the memory has no byte enables.
//
// Ports
//   CLK, RST                 clock (posedge) / asynchronous active-high reset
//   reqValid/reqReady        request handshake, accepted on posedge when ready
//   reqWrite, reqSize,       store flag, size (00 byte, 01 half, 1x word),
//   reqSigned                load sign-extension select
//   reqAddr, reqWData        byte address, right-justified store data
//   respValid, respData,     one-cycle completion pulse, formatted load data
//   misaligned               (held between loads), rejected-request flag
//   memAddress, memWriteData word index and write word to the memory
//   memRead, memWrite        memory strobes (never both high)
//   memReadData              memory read data
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_BITS = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        misaligned,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] memReadData
);

  localparam int AW = ADDR_BITS + 2;  // byte-address bits that reach memory

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          write_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;     // store data, later the merged word
  logic          mis_q;
  logic [31:0]   resp_data_q;

  logic          req_mis;
  logic [7:0]    byte_lane;
  logic [15:0]   half_lane;
  logic [31:0]   load_fmt;
  logic [31:0]   merged;

  // Upper address bits wrap: they never reach the memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^reqAddr[31:AW];

  assign req_mis = ((reqSize == 2'b01) && reqAddr[0]) ||
                   (reqSize[1] && (reqAddr[1:0] != 2'b00));

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    byte_lane = memReadData[{addr_q[1:0], 3'b000} +: 8];
    half_lane = addr_q[1] ? memReadData[31:16] : memReadData[15:0];
    load_fmt  = memReadData;
    merged    = wdata_q;
    case (size_q)
      2'b00: begin
        load_fmt = {{24{signed_q & byte_lane[7]}}, byte_lane};
        merged   = memReadData;
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_fmt = {{16{signed_q & half_lane[15]}}, half_lane};
        merged   = memReadData;
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (reqValid) begin
        if (req_mis)                     state_d = S_RESP;
        else if (reqWrite && reqSize[1]) state_d = S_WR;   // full word: no read
        else                             state_d = S_RD;
      end
      S_RD:    state_d = S_WAIT;
      S_WAIT:  state_d = write_q ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mis_q       <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (reqValid) begin
          write_q  <= reqWrite;
          size_q   <= reqSize;
          signed_q <= reqSigned;
          addr_q   <= reqAddr[AW-1:0];
          wdata_q  <= reqWData;
          mis_q    <= req_mis;
        end
        S_WAIT: begin
          if (write_q) wdata_q     <= merged;
          else         resp_data_q <= load_fmt;
        end
        default: ;
      endcase
    end
  end

  // All memory-side outputs decode from registers only.
  assign reqReady     = (state_q == S_IDLE);
  assign respValid    = (state_q == S_RESP);
  assign misaligned   = respValid && mis_q;
  assign respData     = resp_data_q;
  assign memRead      = (state_q == S_RD);
  assign memWrite     = (state_q == S_WR);
  assign memAddress   = {{(32 - ADDR_BITS){1'b0}}, addr_q[AW-1:2]};
  assign memWriteData = wdata_q;

endmodule
